// File: rtl/apb_arb_pkg.sv
// ============================================================================
// Module   : apb_arb_pkg
// Brief    : Shared state encoding and default widths for the APB arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package apb_arb_pkg;

  localparam int NUM_REQ                = 2;
  localparam int DEF_ADDR_WIDTH         = 8;
  localparam int DEF_DATA_WIDTH         = 8;
  localparam int DEF_TIMEOUT_CYCLES     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
// ============================================================================
// Module   : apb_rr_arbiter
// Brief    : Two-way round-robin grant with a priority pointer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module apb_rr_arbiter
  import apb_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid_i,
  input  logic               update_i,
  output logic [NUM_REQ-1:0] grant_o
);

  // prio_q = index of the requester that wins a tie
  logic prio_q, prio_d;

  always_comb begin
    grant_o = req_valid_i;
    if (&req_valid_i) begin
      grant_o = prio_q ? 2'b10 : 2'b01;
    end
  end

  // The requester granted now becomes lowest priority for the next tie.
  always_comb begin
    prio_d = prio_q;
    if (update_i) begin
      prio_d = grant_o[0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_arbiter.sv
// ============================================================================
// Module   : apb_arbiter
// Brief    : Two-requester round-robin front end onto a single APB master.
//            Optional wait-state timeout enabled by APB_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          err,
  output logic                          transfer,
  output logic                          read_write,
  output logic [ADDR_WIDTH-1:0]         apb_read_add,
  output logic [ADDR_WIDTH-1:0]         apb_write_add,
  output logic [DATA_WIDTH-1:0]         apb_write_data,
  input  logic [DATA_WIDTH-1:0]         pr_data,
  input  logic                          ready
);

  arb_state_e              state_q, state_d;
  logic                    winner_q, winner_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [NUM_REQ-1:0]      grant;
  logic                    grant_upd;
  logic                    win_idx;
  logic                    timeout_hit;

  apb_rr_arbiter u_rr (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .update_i    (grant_upd),
    .grant_o     (grant)
  );

  assign win_idx = grant[1];

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Fires on the last permitted wait cycle so XFER lasts exactly TIMEOUT_CYCLES.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (state_q == XFER && !ready) begin
      cnt_d = cnt_q + 1'b1;
      if (timeout_hit) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q && (state_q == DONE);
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit           = 1'b0;
  assign err                   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    grant_upd = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_upd = 1'b1;
          winner_d  = win_idx;
          write_d   = req_write[win_idx];
          addr_d    = win_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
          wdata_d   = win_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
          state_d   = XFER;
        end
      end
      XFER: begin
        if (ready) begin
          if (!write_q) begin
            rdata_d = pr_data;
          end
          state_d = DONE;
        end else if (timeout_hit) begin
          rdata_d = '0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      winner_q <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  assign transfer       = (state_q == XFER);
  assign read_write     = write_q;
  assign apb_read_add   = addr_q;
  assign apb_write_add  = addr_q;
  assign apb_write_data = wdata_q;
  assign rdata          = rdata_q;
  assign req_done       = (state_q == DONE) ? (winner_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

`default_nettype wire

// File: tb/tb_apb_arbiter.sv
// ============================================================================
// Module   : tb_apb_arbiter
// Brief    : Directed plus randomized bench with a transaction-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_apb_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_write = '0;
  logic [2*AW-1:0] req_addr  = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      req_done;
  logic [DW-1:0]   rdata;
  logic            err;
  logic            transfer;
  logic            read_write;
  logic [AW-1:0]   apb_read_add;
  logic [AW-1:0]   apb_write_add;
  logic [DW-1:0]   apb_write_data;
  logic [DW-1:0]   pr_data = '0;
  logic            ready   = 1'b0;

  apb_arbiter u_dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_done       (req_done),
    .rdata          (rdata),
    .err            (err),
    .transfer       (transfer),
    .read_write     (read_write),
    .apb_read_add   (apb_read_add),
    .apb_write_add  (apb_write_add),
    .apb_write_data (apb_write_data),
    .pr_data        (pr_data),
    .ready          (ready)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Transaction-level model: pending request per requester, tie-break owner, last read data.
  int            prio = 0;
  logic [DW-1:0] exp_rdata = '0;
  logic          p_valid [2];
  logic          p_write [2];
  logic [AW-1:0] p_addr  [2];
  logic [DW-1:0] p_data  [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    for (int i = 0; i < 2; i++) begin
      req_valid[i]          = p_valid[i];
      req_write[i]          = p_write[i];
      req_addr[i*AW +: AW]  = p_addr[i];
      req_wdata[i*DW +: DW] = p_data[i];
    end
  endtask

  task automatic set_txn(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_valid[i] = 1'b1;
    p_write[i] = wr;
    p_addr[i]  = a;
    p_data[i]  = d;
  endtask

  task automatic new_txn(input int i);
    set_txn(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      p_valid[i] = 1'b0;
      p_write[i] = 1'b0;
      p_addr[i]  = '0;
      p_data[i]  = '0;
    end
  endtask

  // Entered during an IDLE cycle; returns in the IDLE cycle after DONE.
  task automatic run_txn(output logic [1:0] done_obs, input int waits, input bit drop,
                         input logic [DW-1:0] rd_val);
    int w;
    apply();
    ready = 1'($urandom_range(0, 1));
    if (p_valid[0] && p_valid[1]) w = prio;
    else if (p_valid[0])          w = 0;
    else                          w = 1;
    prio = 1 - w;
    tick();
    chk("xfer_start", {31'd0, transfer}, 1);
    chk("read_write", {31'd0, read_write}, {31'd0, p_write[w]});
    chk("write_add", {24'd0, apb_write_add}, {24'd0, p_addr[w]});
    chk("read_add", {24'd0, apb_read_add}, {24'd0, p_addr[w]});
    chk("write_data", {24'd0, apb_write_data}, {24'd0, p_data[w]});
    chk("done_early", {30'd0, req_done}, 0);
    if (drop) req_valid[w] = 1'b0;
    req_write = 2'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
    for (int k = 0; k < waits; k++) begin
      ready   = 1'b0;
      pr_data = DW'($urandom);
      tick();
      chk("xfer_hold", {31'd0, transfer}, 1);
      chk("addr_hold", {24'd0, apb_write_add}, {24'd0, p_addr[w]});
      chk("wait_done", {30'd0, req_done}, 0);
    end
    ready   = 1'b1;
    pr_data = rd_val;
    if (!p_write[w]) exp_rdata = rd_val;
    tick();
    done_obs = req_done;
    chk("done_pulse", {30'd0, req_done}, 32'd1 << w);
    chk("done_xfer", {31'd0, transfer}, 0);
    chk("rdata", {24'd0, rdata}, {24'd0, exp_rdata});
    chk("err", {31'd0, err}, 0);
    p_valid[w] = 1'b0;
    ready = 1'($urandom_range(0, 1));
    tick();
    chk("idle_xfer", {31'd0, transfer}, 0);
    chk("idle_done", {30'd0, req_done}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    apply();
    ready = 1'b0;
    prio = 0;
    exp_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  logic [1:0] done_v;
  int         xfer_cnt;

  initial begin
    clear_model();
    repeat (2) @(negedge clk);
    chk("rst_transfer", {31'd0, transfer}, 0);
    chk("rst_rw", {31'd0, read_write}, 0);
    chk("rst_done", {30'd0, req_done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_rdata", {24'd0, rdata}, 0);
    chk("rst_addr", {8'd0, apb_read_add, apb_write_add, apb_write_data}, 0);
    rst = 1'b1;

    // Single write from requester 0, ready two cycles into the transfer.
    set_txn(0, 1'b1, 8'h10, 8'hA5);
    run_txn(done_v, 2, 1'b0, 8'h00);
    chk("wr_done0", {30'd0, done_v}, 32'd1);

    // Read from requester 1.
    set_txn(1, 1'b0, 8'h10, 8'h00);
    run_txn(done_v, 1, 1'b0, 8'h5A);
    chk("rd_done1", {30'd0, done_v}, 32'd2);
    chk("rd_data", {24'd0, rdata}, 32'h5A);

    // Contention from reset: strict alternation.
    do_reset();
    new_txn(0);
    new_txn(1);
    for (int i = 0; i < 4; i++) begin
      run_txn(done_v, $urandom_range(0, 2), 1'b0, DW'($urandom));
      chk("rr_order", {30'd0, done_v}, 32'd1 << (i % 2));
      new_txn(i % 2);
    end
    clear_model();

    // Requester 0 drops valid mid-transfer.
    new_txn(0);
    run_txn(done_v, 2, 1'b1, DW'($urandom));
    chk("drop_done0", {30'd0, done_v}, 32'd1);

    // Reset mid-transfer; pointer would otherwise favour requester 1.
    new_txn(0);
    apply();
    ready = 1'b0;
    tick();
    chk("pre_rst_xfer", {31'd0, transfer}, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_xfer", {31'd0, transfer}, 0);
    chk("rst_mid_done", {30'd0, req_done}, 0);
    chk("rst_mid_rw", {31'd0, read_write}, 0);
    clear_model();
    prio = 0;
    exp_rdata = '0;
    @(negedge clk);
    rst = 1'b1;
    new_txn(0);
    new_txn(1);
    run_txn(done_v, 1, 1'b0, DW'($urandom));
    chk("post_rst_grant", {30'd0, done_v}, 32'd1);
    clear_model();

`ifdef APB_ARB_TIMEOUT_EN
    new_txn(1);
    apply();
    prio = 0;
    ready = 1'b0;
    tick();
    xfer_cnt = transfer ? 1 : 0;
    for (int k = 0; k < 40 && transfer; k++) begin
      tick();
      if (transfer) xfer_cnt++;
    end
    chk("to_cycles", xfer_cnt, 16);
    chk("to_err", {31'd0, err}, 1);
    chk("to_done", {30'd0, req_done}, 32'd2);
    chk("to_rdata", {24'd0, rdata}, 0);
    exp_rdata = '0;
    clear_model();
    tick();
    chk("to_idle_err", {31'd0, err}, 0);
`endif

    // Randomized traffic against the model.
    for (int it = 0; it < 200; it++) begin
      for (int i = 0; i < 2; i++) begin
        if (!p_valid[i] && $urandom_range(0, 1) == 1) new_txn(i);
      end
      if (!p_valid[0] && !p_valid[1]) begin
        apply();
        ready = 1'($urandom_range(0, 1));
        tick();
        chk("idle_gap", {31'd0, transfer}, 0);
      end else begin
        run_txn(done_v, $urandom_range(0, 3), $urandom_range(0, 3) == 0, DW'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, APB address width.
REQ-002 Parameter DATA_WIDTH, default 8, APB data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, wait-state limit; used only with the timeout feature.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  2  per-requester transaction request; bit i = requester i.
REQ-007 req_write  input  2  per-requester direction: 1 = write, 0 = read.
REQ-008 req_addr  input  2*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 req_wdata  input  2*DATA_WIDTH  packed write data, same packing.
REQ-010 req_done  output  2  one-cycle completion pulse to the granted requester.
REQ-011 rdata  output  DATA_WIDTH  read data, valid in the req_done cycle.
REQ-012 err  output  1  timeout flag, pulses together with req_done.
REQ-013 transfer  output  1  APB master transfer request.
REQ-014 read_write  output  1  APB master direction: 1 = write.
REQ-015 apb_read_add  output  ADDR_WIDTH  APB read address.
REQ-016 apb_write_add  output  ADDR_WIDTH  APB write address.
REQ-017 apb_write_data  output  DATA_WIDTH  APB write data.
REQ-018 pr_data  input  DATA_WIDTH  APB read data.
REQ-019 ready  input  1  APB completion; a transfer completes in a cycle where transfer and ready are both 1.

Function
REQ-020 FSM states: IDLE, XFER, DONE.
- IDLE -> XFER on any req_valid.
- XFER -> DONE on ready.
- DONE -> IDLE unconditionally.
REQ-021 In IDLE, the winner SHALL be latched in one cycle: index, direction, address, data.
- transfer = 1 from the next cycle; latency = 1 cycle from the valid sample.
REQ-022 During XFER, transfer, read_write and address/data outputs SHALL hold stable; both address outputs carry the latched address.
REQ-023 On ready in XFER:
- latch pr_data into rdata (reads only; rdata holds for writes);
- enter DONE with transfer = 0.
REQ-024 In DONE, req_done[winner] SHALL be 1 for exactly one cycle.
- Back-to-back grants are separated by at least one transfer = 0 cycle.
REQ-025 Arbitration SHALL be two-way round-robin; the last-completed requester gets lowest priority for the next grant.
REQ-026 Simultaneous requests are resolved by the priority pointer only; a sole requester SHALL win regardless of the pointer.
REQ-027 req_valid deassertion during XFER SHALL be ignored; the latched transaction completes.
REQ-028 Requesters SHALL hold req_valid until their req_done; a still-asserted valid in the DONE cycle is re-arbitrated in IDLE.
REQ-029 ready outside XFER SHALL be ignored.

Reset
REQ-030 rst low SHALL immediately force IDLE with these values:
- transfer, read_write, req_done, err = 0;
- rdata and all address/data outputs = 0;
- priority pointer to requester 0.
REQ-031 Reset mid-XFER SHALL abandon the transaction with no req_done.

Configuration
REQ-032 Macro APB_ARB_TIMEOUT_EN, when defined, SHALL add a wait counter.
- Counter clears on XFER entry and increments each XFER cycle without ready.
- On reaching TIMEOUT_CYCLES: abort to DONE, transfer = 0, rdata = 0, err = 1 with req_done.
REQ-033 Without APB_ARB_TIMEOUT_EN, err SHALL be constant 0 and XFER SHALL wait indefinitely for ready.

Structure
REQ-034 Package apb_arb_pkg SHALL hold:
- the state enum (IDLE, XFER, DONE);
- requester count (2);
- default width constants.
REQ-035 Sub-module apb_rr_arbiter SHALL contain the priority pointer and grant logic.
- Inputs: req_valid, update strobe.
- Outputs: one-hot grant.

Verification
REQ-036 Single write: requester 0 writes addr 8'h10, data 8'hA5; ready 2 cycles after transfer.
- transfer high 1 cycle after valid; read_write = 1; apb_write_add = 8'h10; apb_write_data = 8'hA5; req_done[0] one pulse.
REQ-037 Read: requester 1 reads addr 8'h10; pr_data = 8'h5A with ready.
- rdata = 8'h5A with req_done[1]; read_write = 0.
REQ-038 Contention: both valid from reset.
- Grant order 0, 1, 0, 1.
- transfer low for at least one cycle between transactions.
REQ-039 Valid dropped mid-XFER by requester 0: transaction completes; req_done[0] still pulses.
REQ-040 Reset asserted mid-XFER: transfer = 0 and req_done = 0 immediately; next grant goes to requester 0.
REQ-041 With APB_ARB_TIMEOUT_EN and ready held low:
- abort after 16 XFER cycles;
- err = 1 and req_done pulse in the same cycle; rdata = 0.
